// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Declarations shared by the UART receiver and transmitter:
//   - rx_state_e        : receiver state encoding
//   - calc_bit_cycles() : clocks per serial bit for a given clock and baud rate
//   - calc_half_cycles(): clocks per half bit (mid-bit sampling offset)
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Integer division: any fractional remainder becomes a small baud-rate
    // error that the mid-bit sampling absorbs.
    function automatic int unsigned calc_bit_cycles(input int unsigned clk_hz,
                                                    input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned calc_half_cycles(input int unsigned clk_hz,
                                                     input int unsigned baud);
        return calc_bit_cycles(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value.
//
// Ports:
//   clock_i    : system clock
//   reset_i    : synchronous active-high reset (all flops preset to idle-high)
//   rx_i       : raw asynchronous serial input, idle high
//   rx_sync_o  : synchronized serial line
//   fall_o     : one-cycle pulse when rx_sync_o goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clock_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic fall_o
);

    logic meta_q;   // first stage, may go metastable
    logic sync_q;   // second stage, safe to use
    logic prev_q;   // previous synchronized value, for edge detection

    // Presetting to 1 keeps a reset release from looking like a start edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync_o = sync_q;
    assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receive.sv
// -----------------------------------------------------------------------------
// uart_receive
// 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no
// parity. The line is synchronized, a falling edge in IDLE starts a frame,
// the start bit is re-checked at mid-bit (glitch rejection) and every later
// bit is sampled one bit period after the previous sample point.
//
// Parameters:
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : serial bit rate
//
// Ports:
//   clock      : system clock, all state updates on rising edge
//   reset      : synchronous active-high reset
//   rx         : asynchronous serial line, idle high
//   dataOut    : last correctly framed byte
//   dataValid  : one-cycle pulse, dataOut has just been updated
//   frameError : one-cycle pulse, stop bit was sampled low
//   busy       : high whenever a frame is being tracked (state != IDLE)
//
// Build option:
//   UART_RX_MAJORITY_EN : when defined, each start/data/stop decision is the
//   2-of-3 majority of the synchronized line over three consecutive clocks
//   centred on the nominal sample point. When undefined a single sample is
//   taken and no voting logic exists.
// -----------------------------------------------------------------------------
module uart_receive
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 4_992_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       frameError,
    output logic       busy
);

    localparam int unsigned BIT_CYCLES  = calc_bit_cycles(CLK_HZ, BAUD);
    localparam int unsigned HALF_CYCLES = calc_half_cycles(CLK_HZ, BAUD);
    localparam int          CNT_W       = $clog2(BIT_CYCLES);

    // The counter runs from 0, so value N-1 marks the end of N elapsed
    // cycles. With majority voting the start decision moves one clock later
    // so that the three votes straddle the mid-point; since the counter is
    // cleared at that decision, every later decision inherits the same
    // one-clock shift and its votes are centred too.
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned START_DECIDE = HALF_CYCLES;
`else
    localparam int unsigned START_DECIDE = HALF_CYCLES - 1;
`endif

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DECIDE);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Line synchronizer and start-edge detection
    // -------------------------------------------------------------------------
    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clock_i   (clock),
        .reset_i   (reset),
        .rx_i      (rx),
        .rx_sync_o (rx_s),
        .fall_o    (rx_fall)
    );

    // -------------------------------------------------------------------------
    // Bit decision: single sample or 2-of-3 vote
    // -------------------------------------------------------------------------
    logic sample_bit;

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one clock ago, hist_q[1] two clocks ago; together with
    // the current value they form the three votes at the decision clock.
    logic [1:0] hist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_bit = (hist_q[1] & hist_q[0]) |
                        (hist_q[1] & rx_s)      |
                        (hist_q[0] & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    // -------------------------------------------------------------------------
    // Frame FSM: state register
    // -------------------------------------------------------------------------
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // clocks within the current bit
    logic [2:0]       idx_q,   idx_d;     // data bit being received
    logic [7:0]       shift_q, shift_d;   // data bits assembled so far
    logic [7:0]       data_q,  data_d;    // last good byte
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             busy_q,  busy_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM: next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                // Only a genuine 1 -> 0 transition starts a frame, so a line
                // stuck low after a break cannot retrigger reception.
                if (rx_fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end

            RX_START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d = '0;
                    if (!sample_bit) begin
                        state_d = RX_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        // Line back high by mid-bit: noise, not a start bit.
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sample_bit;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    // Returning to IDLE at mid stop bit leaves half a bit to
                    // catch the start edge of a back-to-back frame.
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = RX_IDLE;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase

        // Registered from the next state so busy lines up with state_q.
        busy_d = (state_d != RX_IDLE);
    end

    assign dataOut    = data_q;
    assign dataValid  = valid_q;
    assign frameError = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_receive
// Directed bench for uart_receive at default parameters (520 clocks per bit).
// Serial frames are driven one clock at a time; a negedge monitor counts
// dataValid / frameError pulses and logs received bytes.
// -----------------------------------------------------------------------------
module tb_uart_receive;

    localparam int BIT  = 520;
    localparam int HALF = 260;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       frameError;
    logic       busy;

    always #5 clock = ~clock;

    uart_receive dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .frameError (frameError),
        .busy       (busy)
    );

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int valid_cnt   = 0;
    int ferr_cnt    = 0;
    int both_cnt    = 0;
    int last_valid  = 0;
    int frame_start = 0;
    logic [7:0] got [$];

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (dataValid) begin
            valid_cnt  = valid_cnt + 1;
            last_valid = cyc;
            got.push_back(dataOut);
            $display("rx byte %02h at cycle %0d", dataOut, cyc);
        end
        if (frameError) begin
            ferr_cnt = ferr_cnt + 1;
            $display("frame error at cycle %0d", cyc);
        end
        if (dataValid && frameError) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; every wait keeps that
    // alignment so consecutive frames are truly back-to-back.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one 8N1 frame (or its first max_cycles clocks). With glitch set,
    // the clock at the centre of every data bit is inverted.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic glitch, input int max_cycles);
        logic v;
        frame_start = cyc;
        for (int k = 0; k < 10 * BIT && k < max_cycles; k++) begin
            int bi;
            int off;
            bi  = k / BIT;
            off = k % BIT;
            if (bi == 0)      v = 1'b0;
            else if (bi == 9) v = stop_bit;
            else              v = b[bi-1];
            if (glitch && bi >= 1 && bi <= 8 && off == HALF) v = ~v;
            rx = v;
            @(posedge clock);
            #1;
        end
    endtask

    logic [7:0] c3_expect;
    int         lat_expect;

    initial begin
`ifdef UART_RX_MAJORITY_EN
        c3_expect  = 8'hC3;
        lat_expect = 4944;
`else
        c3_expect  = 8'h3C;
        lat_expect = 4943;
`endif
        // ---------------- reset state ----------------
        reset = 1'b1;
        rx    = 1'b1;
        idle(5);
        check("rst_dataOut",    32'(dataOut),    32'h00);
        check("rst_dataValid",  32'(dataValid),  32'h0);
        check("rst_frameError", 32'(frameError), 32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        reset = 1'b0;
        idle(20);

        // ---------------- single frame 0x0D ----------------
        send_frame(8'h0D, 1'b1, 1'b0, 10 * BIT);
        idle(50);
        check("b0D_valid_cnt", 32'(valid_cnt), 32'd1);
        check("b0D_byte",      32'(got[0]),    32'h0D);
        check("b0D_dataOut",   32'(dataOut),   32'h0D);
        check("b0D_ferr_cnt",  32'(ferr_cnt),  32'd0);
        check("b0D_latency",   32'(last_valid - frame_start - 1), 32'(lat_expect));
        check("b0D_busy",      32'(busy),      32'h0);

        // ---------------- back-to-back 0x55, 0xAA ----------------
        send_frame(8'h55, 1'b1, 1'b0, 10 * BIT);
        send_frame(8'hAA, 1'b1, 1'b0, 10 * BIT);
        idle(50);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_first",     32'(got[1]),    32'h55);
        check("b2b_second",    32'(got[2]),    32'hAA);
        check("b2b_ferr_cnt",  32'(ferr_cnt),  32'd0);

        // ---------------- short low pulse rejected ----------------
        rx = 1'b0;
        idle(50);
        check("glitch_busy_mid", 32'(busy), 32'h1);
        idle(50);
        rx = 1'b1;
        idle(400);
        check("glitch_busy_end",  32'(busy),      32'h0);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd3);
        check("glitch_ferr_cnt",  32'(ferr_cnt),  32'd0);
        check("glitch_dataOut",   32'(dataOut),   32'hAA);

        // ---------------- frame error, then line held low ----------------
        send_frame(8'h3C, 1'b0, 1'b0, 10 * BIT);
        check("ferr_cnt",       32'(ferr_cnt),  32'd1);
        check("ferr_valid_cnt", 32'(valid_cnt), 32'd3);
        check("ferr_dataOut",   32'(dataOut),   32'hAA);
        idle(1000);
        check("break_busy",     32'(busy),      32'h0);
        rx = 1'b1;
        idle(100);
        check("break_busy_hi",  32'(busy),      32'h0);
        check("break_ferr_cnt", 32'(ferr_cnt),  32'd1);

        // ---------------- reset during data bit 4 ----------------
        send_frame(8'hA5, 1'b1, 1'b0, 5 * BIT + HALF);
        check("midrst_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        rx    = 1'b1;
        idle(1);
        check("midrst_dataOut",    32'(dataOut),    32'h00);
        check("midrst_dataValid",  32'(dataValid),  32'h0);
        check("midrst_frameError", 32'(frameError), 32'h0);
        check("midrst_busy",       32'(busy),       32'h0);
        reset = 1'b0;
        idle(20);
        check("midrst_valid_cnt", 32'(valid_cnt), 32'd3);
        check("midrst_ferr_cnt",  32'(ferr_cnt),  32'd1);

        send_frame(8'hA5, 1'b1, 1'b0, 10 * BIT);
        idle(50);
        check("a5_valid_cnt", 32'(valid_cnt), 32'd4);
        check("a5_byte",      32'(got[3]),    32'hA5);
        check("a5_dataOut",   32'(dataOut),   32'hA5);

        // ---------------- mid-bit glitches on 0xC3 ----------------
        send_frame(8'hC3, 1'b1, 1'b1, 10 * BIT);
        idle(50);
        check("c3_valid_cnt", 32'(valid_cnt), 32'd5);
        check("c3_dataOut",   32'(dataOut),   32'(c3_expect));
        check("c3_ferr_cnt",  32'(ferr_cnt),  32'd1);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter CLK_HZ, default 4_992_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate; BIT_CYCLES = CLK_HZ/BAUD (integer division, 520 at defaults), HALF_CYCLES = BIT_CYCLES/2 (260).
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 dataOut  output  8  last correctly framed byte received.
REQ-007 dataValid  output  1  one-cycle pulse, dataOut newly updated.
REQ-008 frameError  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; all further references are to synchronized rx (rxS).
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 States SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: on rxS falling edge (previous 1, current 0) go to START and clear the bit-period counter.
REQ-014 START: after HALF_CYCLES cycles sample rxS; 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: after each BIT_CYCLES cycles sample rxS into shift register bit [index]; after index 7 go to STOP.
REQ-016 STOP: after BIT_CYCLES cycles sample rxS; 1 -> load dataOut, pulse dataValid for exactly one cycle, go to IDLE; 0 -> pulse frameError for one cycle, dataOut unchanged, go to IDLE.
REQ-017 Outputs SHALL be registered; dataValid/frameError assert on the clock edge after the stop sample.
REQ-018 A new falling edge is detected only from IDLE; a frame beginning immediately after a stop bit (back-to-back) SHALL be received with no dropped byte.
REQ-019 After a frame error with rx held low (break), no new frame SHALL start until rxS has returned to 1 and fallen again.
REQ-020 dataValid and frameError SHALL never be high in the same cycle.
REQ-021 Bit-period counter width SHALL be $clog2(BIT_CYCLES); no wrap within a bit period.

Reset
REQ-022 reset high SHALL force state IDLE, counter 0, bit index 0, shift register 0, dataOut 8'h00, dataValid 0, frameError 0, busy 0, synchronizer flops 1.
REQ-023 Reset mid-frame SHALL abort the frame with no dataValid/frameError pulse; reception resumes on next falling edge after reset deasserts.

Configuration
REQ-024 Macro UART_RX_MAJORITY_EN defined: each start/data/stop decision SHALL be the 2-of-3 majority of rxS sampled at counts HALF-1, HALF, HALF+1 of the bit; decision timing (REQ-014..016) unchanged, taken at HALF+1 for start.
REQ-025 Macro undefined: single sample at the points given in REQ-014..016; no majority logic synthesized.

Structure
REQ-026 Package uart_pkg SHALL hold the rx state enum typedef and a function computing BIT_CYCLES from CLK_HZ and BAUD, shared with uart_transmit.
REQ-027 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer and falling-edge detect; all else in uart_receive.

Verification
REQ-028 Loopback from uart_transmit (same parameters) sending 8'h0D -> dataOut 8'h0D, one dataValid pulse ~9.5*520 cycles after tx falls, frameError never high.
REQ-029 Back-to-back 8'h55 then 8'hAA with no idle gap -> two dataValid pulses, dataOut 8'h55 then 8'hAA.
REQ-030 rx low for 100 cycles then high -> return to IDLE at HALF check, no pulse, busy low again, dataOut unchanged.
REQ-031 Frame 8'h3C with stop bit forced 0 -> one frameError pulse, no dataValid, dataOut keeps previous byte.
REQ-032 reset asserted during data bit 4 -> all outputs to reset values next cycle, no pulse; following frame 8'hA5 received correctly.
REQ-033 With UART_RX_MAJORITY_EN, 1-cycle inverted glitch at mid-point of each data bit of 8'hC3 -> dataOut 8'hC3; without macro, same stimulus -> mismatch detected (8'h3C).
